// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - note-table melody player driving a tone clock divider
module melody_sequencer #(
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [3:0] song_len,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic [2:0] control,
  output logic       div_reset,
  output logic       tone_en,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int TICK_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state, state_nx, exit_state;
  logic [6:0]        note_table [16];
  logic [6:0]        cur_entry;
  logic [2:0]        beat_cnt, beat_nx;
  logic [TICK_W-1:0] tick_cnt, tick_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_nx;
  logic [3:0]        step_idx_nx, exit_idx;
  logic [2:0]        control_nx;
  logic              tone_en_nx, div_reset_nx, done_nx, exit_done;

  assign cur_entry = note_table[step_idx];
  assign busy      = (state != IDLE);

  // Note table is only writable while idle so a playing song never changes under us
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) note_table[wr_addr] <= wr_data;
  end

  // Where playback goes once a note (and its gap) has finished
  always_comb begin
    exit_state = IDLE;
    exit_idx   = step_idx;
    exit_done  = 1'b0;
    if (step_idx < song_len) begin
      exit_state = LOAD;
      exit_idx   = step_idx + 4'd1;
    end else if (loop) begin
      exit_state = LOAD;
      exit_idx   = 4'd0;
    end else begin
      exit_done  = 1'b1;
    end
  end

  // Next-state and next-output logic; stop overrides everything outside IDLE
  always_comb begin
    state_nx     = state;
    step_idx_nx  = step_idx;
    control_nx   = control;
    tone_en_nx   = tone_en;
    div_reset_nx = 1'b0;
    done_nx      = 1'b0;
    beat_nx      = beat_cnt;
    tick_nx      = tick_cnt;
    gap_nx       = gap_cnt;
    if (state != IDLE && stop) begin
      state_nx   = IDLE;
      tone_en_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_nx    = LOAD;
            step_idx_nx = 4'd0;
          end
        end
        LOAD: begin
          state_nx     = PLAY;
          control_nx   = cur_entry[5:3];
          tone_en_nx   = ~cur_entry[6];
          div_reset_nx = 1'b1;
          beat_nx      = cur_entry[2:0];
          tick_nx      = '0;
        end
        PLAY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nx = '0;
            if (beat_cnt == 3'd0) begin
              if (GAP_TICKS > 0) begin
                state_nx   = GAP;
                gap_nx     = '0;
                tone_en_nx = 1'b0;
              end else begin
                state_nx    = exit_state;
                step_idx_nx = exit_idx;
                done_nx     = exit_done;
                if (exit_done) tone_en_nx = 1'b0;
              end
            end else begin
              beat_nx = beat_cnt - 3'd1;
            end
          end else begin
            tick_nx = tick_cnt + TICK_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_nx      = '0;
            state_nx    = exit_state;
            step_idx_nx = exit_idx;
            done_nx     = exit_done;
          end else begin
            gap_nx = gap_cnt + GAP_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step_idx  <= 4'd0;
      control   <= 3'd0;
      tone_en   <= 1'b0;
      div_reset <= 1'b0;
      done      <= 1'b0;
      beat_cnt  <= 3'd0;
      tick_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      step_idx  <= step_idx_nx;
      control   <= control_nx;
      tone_en   <= tone_en_nx;
      div_reset <= div_reset_nx;
      done      <= done_nx;
      beat_cnt  <= beat_nx;
      tick_cnt  <= tick_nx;
      gap_cnt   <= gap_nx;
    end
  end

endmodule
